// File: rtl/ahb_lock_arbiter.sv
// ahb_lock_arbiter
// Two-master AHB-Lite arbiter (M1 = instruction fetch, M2 = data) with a
// default master, locked-sequence hold and a bounded tenure per grant.
// Optional feature macro: ARB_RR_EN
//   defined   : round-robin tie-break plus MAX_TENURE limit while the other
//               master is waiting.
//   undefined : fixed priority M1 over M2; no last-master or tenure state.
module ahb_lock_arbiter #(
  parameter int unsigned MAX_TENURE  = 4,
  parameter int unsigned MASTER_BITS = 2
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HBUSREQ_M1,
  input  logic                   HBUSREQ_M2,
  input  logic                   HLOCK_M1,
  input  logic                   HLOCK_M2,
  input  logic [1:0]             HTRANS,
  input  logic                   HREADY,
  output logic                   HGRANT_M1,
  output logic                   HGRANT_M2,
  output logic                   HGRANT_DEF,
  output logic [MASTER_BITS-1:0] HMASTER,
  output logic                   HMASTLOCK
);

  // Encoding doubles as the HMASTER value of each owner.
  typedef enum logic [1:0] {
    GNT_DEF = 2'd0,
    GNT_M1  = 2'd1,
    GNT_M2  = 2'd2
  } gnt_t;

  gnt_t gnt;
  gnt_t gnt_nxt;
  logic req_g;
  logic req_o;
  logic lock_g;
  logic seq_busy;
  logic tenure_ok;
  logic held;

`ifdef ARB_RR_EN
  gnt_t       last;
  logic [3:0] tenure;
`endif

  // Hold test for the current owner and next-owner selection, using only
  // the inputs present in this cycle.
  always_comb begin
    req_g   = 1'b0;
    req_o   = 1'b0;
    lock_g  = 1'b0;
    gnt_nxt = GNT_DEF;
    case (gnt)
      GNT_M1: begin
        req_g  = HBUSREQ_M1;
        req_o  = HBUSREQ_M2;
        lock_g = HLOCK_M1;
      end
      GNT_M2: begin
        req_g  = HBUSREQ_M2;
        req_o  = HBUSREQ_M1;
        lock_g = HLOCK_M2;
      end
      default: ;
    endcase
    // A locked sequence only ends when an IDLE is seen on the bus.
    seq_busy = HMASTLOCK && (HTRANS != 2'b00);
`ifdef ARB_RR_EN
    tenure_ok = (tenure < 4'(MAX_TENURE)) || !req_o;
`else
    tenure_ok = !req_o;
`endif
    held = (gnt != GNT_DEF) && (lock_g || seq_busy || (req_g && tenure_ok));
    if (held) begin
      gnt_nxt = gnt;
    end else if (HBUSREQ_M1 && HBUSREQ_M2) begin
`ifdef ARB_RR_EN
      gnt_nxt = (last == GNT_M1) ? GNT_M2 : GNT_M1;
`else
      gnt_nxt = GNT_M1;
`endif
    end else if (HBUSREQ_M1) begin
      gnt_nxt = GNT_M1;
    end else if (HBUSREQ_M2) begin
      gnt_nxt = GNT_M2;
    end else begin
      gnt_nxt = GNT_DEF;
    end
  end

  // Grant FSM with registered grant/ownership outputs; advances only on
  // HREADY=1 edges so wait states freeze every register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt        <= GNT_DEF;
      HGRANT_DEF <= 1'b1;
      HGRANT_M1  <= 1'b0;
      HGRANT_M2  <= 1'b0;
      HMASTER    <= '0;
      HMASTLOCK  <= 1'b0;
`ifdef ARB_RR_EN
      last       <= GNT_M2;
      tenure     <= '0;
`endif
    end else if (HREADY) begin
      gnt        <= gnt_nxt;
      HGRANT_DEF <= (gnt_nxt == GNT_DEF);
      HGRANT_M1  <= (gnt_nxt == GNT_M1);
      HGRANT_M2  <= (gnt_nxt == GNT_M2);
      // Ownership follows the grant that was in force during this cycle.
      HMASTER    <= MASTER_BITS'(gnt);
      HMASTLOCK  <= lock_g;
`ifdef ARB_RR_EN
      if (gnt_nxt != gnt) begin
        tenure <= '0;
        if (gnt_nxt != GNT_DEF) begin
          last <= gnt_nxt;
        end
      end else if (HTRANS[1] && (HMASTER == MASTER_BITS'(gnt)) &&
                   (tenure < 4'(MAX_TENURE))) begin
        tenure <= tenure + 4'd1;
      end
`endif
    end
  end

endmodule
